// File: rtl/cpu_alu_pkg.sv
// Shared ALU definitions: UDIV opcode, NZCV flag bit positions and divider FSM states.
package cpu_alu_pkg;

  localparam logic [2:0] ALUCTL_UDIV = 3'b101;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } udiv_state_t;

endpackage

// File: rtl/udiv_step.sv
// One radix-2 restoring division iteration; purely combinational.
module udiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < divisor always holds on entry, so the shifted value fits in WIDTH+1 bits
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor};

  always_comb begin
    rem_next = shifted[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/udiv_seq_unit.sv
// Multi-cycle unsigned divider (UDIV) with valid/ready request and response channels.
// Optional trivial-case shortcut in IDLE is enabled by defining UDIV_EARLY_OUT_EN.
module udiv_seq_unit
  import cpu_alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_dividend,
  input  logic [WIDTH-1:0] req_divisor,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_quotient,
  output logic [WIDTH-1:0] rsp_remainder,
  output logic [3:0]       rsp_flags,
  output logic             rsp_divzero
);

  udiv_state_t      state_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvsr_q;
  logic [WIDTH-1:0] rem_d, quo_d;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       flags_q;
  logic             divzero_q;

  function automatic logic [3:0] flags_of(input logic [WIDTH-1:0] q);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = q[WIDTH-1];
    f[FLAG_Z] = (q == '0);
    return f;
  endfunction

  udiv_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvsr_q),
    .rem_next (rem_d),
    .quo_next (quo_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      cnt_q     <= '0;
      flags_q   <= '0;
      divzero_q <= 1'b0;
    end else if (flush) begin
      state_q   <= IDLE;
      divzero_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            dvsr_q    <= req_divisor;
            divzero_q <= 1'b0;
            if (req_divisor == '0) begin
              quo_q     <= '1;
              rem_q     <= req_dividend;
              flags_q   <= flags_of('1);
              divzero_q <= 1'b1;
              state_q   <= DONE;
            end
`ifdef UDIV_EARLY_OUT_EN
            else if (req_dividend < req_divisor) begin
              quo_q   <= '0;
              rem_q   <= req_dividend;
              flags_q <= flags_of('0);
              state_q <= DONE;
            end else if (req_divisor == WIDTH'(1)) begin
              quo_q   <= req_dividend;
              rem_q   <= '0;
              flags_q <= flags_of(req_dividend);
              state_q <= DONE;
            end
`endif
            else begin
              rem_q   <= '0;
              quo_q   <= req_dividend;
              cnt_q   <= CNT_W'(WIDTH);
              flags_q <= '0;
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            flags_q <= flags_of(quo_d);
            state_q <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign rsp_valid     = (state_q == DONE);
  assign rsp_quotient  = quo_q;
  assign rsp_remainder = rem_q;
  assign rsp_flags     = flags_q;
  assign rsp_divzero   = divzero_q;

endmodule
